folded_maj_seq: RTL and testbench

Sequential folded majority evaluator for the wide majority datapath. It accepts one N-bit input vector per transaction and evaluates it CHUNK bits per cycle through a narrow popcount slice. It accumulates the count and compares it against a fixed threshold, producing the majority result with its count. It sits in front of, or in place of, the flat N-input majority block wherever area matters more than latency. It uses valid/ready handshakes on both sides.

---
 rtl/folded_maj_seq.sv | 133 +++++++++++++
 tb/tb_folded_maj_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/folded_maj_seq.sv
// folded_maj_seq: sequential majority evaluator for an N-bit vector.
// The vector is folded through a CHUNK-bit popcount slice, one chunk per
// cycle, and the accumulated count is compared against THRESH.
// Optional feature: define FOLDMAJ_EARLY_EXIT_EN to finish as soon as the
// outcome is decided (out_count then reports the partial count at exit).
module folded_maj_seq #(
    parameter int N      = 55,
    parameter int CHUNK  = 8,
    parameter int THRESH = (N + 1) / 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_y,
    output logic [$clog2(N+1)-1:0] out_count
);

    localparam int NCHUNK = (N + CHUNK - 1) / CHUNK;
    localparam int CW     = $clog2(N + 1);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PW     = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [N-1:0]  sr;
    logic [CW-1:0] count;
    logic [IW-1:0] idx;
    logic [PW-1:0] chunk_pop;
    logic [CW-1:0] count_next;
    logic          last_chunk;
    logic          early_exit;

    // Popcount of the chunk currently at the bottom of the shift register.
    // NOTE: every always_comb output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + PW'(sr[i]);
        end
    end

    // Running count after folding in this cycle's chunk; cannot exceed N.
    always_comb begin
        count_next = count + CW'(chunk_pop);
        last_chunk = (idx == IW'(NCHUNK - 1));
    end

`ifdef FOLDMAJ_EARLY_EXIT_EN
    // Outcome decided: threshold reached, or unreachable with the bits left.
    always_comb begin
        early_exit = (int'(count_next) >= THRESH) ||
                     ((int'(count_next) + N) < (THRESH + CHUNK * (int'(idx) + 1)));
    end
`else
    // Full evaluation always folds every chunk.
    always_comb begin
        early_exit = 1'b0;
    end
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)                 next_state = ACCUM;
            ACCUM:   if (last_chunk || early_exit) next_state = DONE;
            DONE:    if (out_ready)                next_state = IDLE;
            default:                               next_state = IDLE;
        endcase
    end

    // Datapath: load on accept, fold one chunk per ACCUM cycle, register result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            count     <= '0;
            idx       <= '0;
            out_y     <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr    <= in_x;
                        count <= '0;
                        idx   <= '0;
                    end
                end
                ACCUM: begin
                    sr    <= sr >> CHUNK;
                    count <= count_next;
                    idx   <= idx + IW'(1);
                    // Early exit only fires once the outcome is fixed, so the
                    // comparison on the partial count is still exact.
                    if (next_state == DONE) begin
                        out_y     <= (count_next >= CW'(THRESH));
                        out_count <= count_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs depend on state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

endmodule

// File: tb/tb_folded_maj_seq.sv
// tb_folded_maj_seq: directed and random checks of folded_maj_seq with a
// scoreboard of expected results built from an independent popcount model.
module tb_folded_maj_seq;

    localparam int N      = 55;
    localparam int CHUNK  = 8;
    localparam int THRESH = 28;
    localparam int NCHUNK = 7;
    localparam int CW     = 6;

    typedef struct {
        logic          y;
        logic [CW-1:0] cnt;
        int            lat;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_x;
    logic          out_valid;
    logic          out_ready;
    logic          out_y;
    logic [CW-1:0] out_count;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   n_in;
    int   n_out;

    folded_maj_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chunk-by-chunk reference: latency and reported count, exact majority.
    function automatic exp_t model(input logic [N-1:0] x);
        exp_t        e;
        logic [63:0] p;
        int          cnt;
        int          full;
        bit          fin;
        p    = {{(64 - N){1'b0}}, x};
        cnt  = 0;
        full = 0;
        fin  = 0;
        e.lat = NCHUNK;
        for (int i = 0; i < N; i++) full += int'(x[i]);
        for (int c = 0; c < NCHUNK; c++) begin
            if (!fin) begin
                for (int b = 0; b < CHUNK; b++) cnt += int'(p[c * CHUNK + b]);
                e.lat = c + 1;
                if (c == NCHUNK - 1) fin = 1;
`ifdef FOLDMAJ_EARLY_EXIT_EN
                if (cnt >= THRESH || cnt + (N - CHUNK * (c + 1)) < THRESH) fin = 1;
`endif
            end
        end
        e.y   = (full >= THRESH);
        e.cnt = CW'(cnt);
        return e;
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[N-1:0];
    endfunction

    // One transaction; called right after a posedge+#1 with the DUT in IDLE.
    task automatic run_txn(input logic [N-1:0] x, input int stall, input bit hold_chk);
        exp_t e;
        exp_t got;
        int   lat;
        e = model(x);
        sb.push_back(e);
        in_x     = x;
        in_valid = 1'b1;
        if (hold_chk) check("in_ready_idle", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x     = rand_vec();
        n_in++;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            in_x = rand_vec();
        end
        check("out_valid_seen", out_valid, 1'b1);
        check("latency", lat, e.lat);
        got = sb.pop_front();
        check("out_y", out_y, got.y);
        check("out_count", out_count, got.cnt);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            in_x = rand_vec();
            if (hold_chk) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_y", out_y, got.y);
                check("hold_count", out_count, got.cnt);
                check("hold_in_ready", in_ready, 1'b0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_out++;
        check("post_out_valid", out_valid, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [N-1:0] v;
        int           seen;
        n_checks  = 0;
        n_fail    = 0;
        n_in      = 0;
        n_out     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;

        // Reset values.
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_y", out_y, 1'b0);
        check("rst_out_count", out_count, 6'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors around the threshold and the partial last chunk.
        run_txn('0, 0, 1'b1);
        v = '0; v[27:0] = '1;             run_txn(v, 0, 1'b1);
        v = '0; v[26:0] = '1;             run_txn(v, 0, 1'b1);
        v = '0; v[26:0] = '1; v[54] = 1;  run_txn(v, 0, 1'b1);
        v = '0; v[54:28] = '1;            run_txn(v, 0, 1'b1);
        v = '0; v[54] = 1'b1;             run_txn(v, 0, 1'b1);
        v = {28{2'b01}};                  run_txn(v, 0, 1'b1);
        run_txn('1, 0, 1'b1);

        // Long output stall with in_x toggling.
        v = '0; v[40:10] = '1;
        run_txn(v, 10, 1'b1);

        // Abort in the 3rd ACCUM cycle.
        sb.push_back(model('1));
        in_x     = '1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_y", out_y, 1'b0);
        check("abort_out_count", out_count, 6'd0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check("abort_no_output", seen, 0);
        v = '0; v[27:0] = '1;
        run_txn(v, 0, 1'b1);

        // Back-to-back random vectors with random output stalls.
        for (int t = 0; t < 4000; t++) begin
            v = rand_vec();
            if ($urandom_range(0, 1) == 0) begin
                v = v & rand_vec();
                if ($urandom_range(0, 1) == 0) v = v | rand_vec();
            end
            run_txn(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0);
        end

        check("txn_in_eq_out", n_in, n_out);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
